// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared op/state encodings and iteration count for mul_div_unit
package mul_div_pkg;
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } state_e;
    localparam int ITERATIONS = 32;
endpackage

// File: rtl/mul_div_if.sv
// mul_div_if: request / HI-LO bus between the Execute stage (master) and mul_div_unit (slave)
interface mul_div_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        hiLoWrite;
    logic        hiLoSel;
    logic [31:0] hiLoData;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        divByZero;
    modport master (
        output start, op, opA, opB, hiLoWrite, hiLoSel, hiLoData, flush,
        input  hi, lo, busy, done, divByZero
    );
    modport slave (
        input  start, op, opA, opB, hiLoWrite, hiLoSel, hiLoData, flush,
        output hi, lo, busy, done, divByZero
    );
endinterface

// File: rtl/mul_div_unit_sign.sv
// MulDivSign: conditional two's-complement negate of a W-bit value
module MulDivSign #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);
    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO plus MTHI/MTLO; divider built only when MULDIV_DIV_EN is defined
module mul_div_unit
    import mul_div_pkg::*;
(
    input logic     clock,
    input logic     reset,
    mul_div_if.slave md
);
    localparam logic [4:0] LAST_COUNT = 5'(ITERATIONS - 1);
    state_e      r_state;
    logic [4:0]  r_count;
    logic [32:0] r_acc;
    logic [31:0] r_q, r_b, r_hi, r_lo;
    logic        r_div, r_neg_lo, r_done;
    logic        w_sa, w_sb;
    logic [31:0] w_mag_a, w_mag_b;
    logic [32:0] w_msum;
    logic [64:0] w_mshift;
    logic [63:0] w_prod_fix;

    assign w_sa = ~md.op[0] & md.opA[31];
    assign w_sb = ~md.op[0] & md.opB[31];

    MulDivSign #(.W(32)) u_mag_a (.i_val(md.opA), .i_neg(w_sa), .o_val(w_mag_a));
    MulDivSign #(.W(32)) u_mag_b (.i_val(md.opB), .i_neg(w_sb), .o_val(w_mag_b));
    MulDivSign #(.W(64)) u_prod  (.i_val({r_acc[31:0], r_q}), .i_neg(r_neg_lo), .o_val(w_prod_fix));

    // r_acc[32] is always 0 between multiply steps, so the 33-bit sum cannot overflow
    assign w_msum   = r_acc + {1'b0, r_b};
    assign w_mshift = r_q[0] ? ({w_msum, r_q} >> 1) : ({r_acc, r_q} >> 1);

`ifdef MULDIV_DIV_EN
    logic        r_neg_hi, r_dz;
    logic [32:0] w_rem_s, w_trial;
    logic [31:0] w_quot_fix, w_rem_fix;

    assign w_rem_s = {r_acc[31:0], r_q[31]};
    assign w_trial = w_rem_s - {1'b0, r_b};

    MulDivSign #(.W(32)) u_quot (.i_val(r_q),         .i_neg(r_neg_lo), .o_val(w_quot_fix));
    MulDivSign #(.W(32)) u_rem  (.i_val(r_acc[31:0]), .i_neg(r_neg_hi), .o_val(w_rem_fix));

    assign md.divByZero = r_dz;
`else
    assign md.divByZero = 1'b0;
`endif

    assign md.hi   = r_hi;
    assign md.lo   = r_lo;
    assign md.busy = (r_state != ST_IDLE);
    assign md.done = r_done;

    // Control FSM, iterative datapath and HI/LO ownership, all on the falling clock edge
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_div    <= 1'b0;
            r_neg_lo <= 1'b0;
            r_done   <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_neg_hi <= 1'b0;
            r_dz     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_dz   <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (md.hiLoWrite) begin
                        if (md.hiLoSel) r_hi <= md.hiLoData;
                        else            r_lo <= md.hiLoData;
                    end
                    if (md.start && !md.flush) begin
                        r_div    <= md.op[1];
                        r_neg_lo <= w_sa ^ w_sb;
                        r_acc    <= '0;
                        r_count  <= '0;
                        // dividend sits in the quotient register; multiplier in the shifting low half
                        r_q      <= md.op[1] ? w_mag_a : w_mag_b;
                        r_b      <= md.op[1] ? w_mag_b : w_mag_a;
`ifdef MULDIV_DIV_EN
                        r_neg_hi <= w_sa;
                        r_state  <= ST_CALC;
`else
                        r_state  <= md.op[1] ? ST_FIX : ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    if (md.flush) begin
                        r_state <= ST_IDLE;
                    end else begin
`ifdef MULDIV_DIV_EN
                        if (r_div)
                            {r_acc, r_q} <= w_trial[32] ? {w_rem_s, r_q[30:0], 1'b0}
                                                        : {w_trial, r_q[30:0], 1'b1};
                        else
                            {r_acc, r_q} <= w_mshift;
`else
                        {r_acc, r_q} <= w_mshift;
`endif
                        r_count <= r_count + 5'd1;
                        if (r_count == LAST_COUNT) r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (!md.flush) begin
`ifdef MULDIV_DIV_EN
                        {r_hi, r_lo} <= r_div ? {w_rem_fix, w_quot_fix} : w_prod_fix;
                        r_dz         <= r_div && (r_b == 32'd0);
`else
                        if (!r_div) {r_hi, r_lo} <= w_prod_fix;
`endif
                        r_done <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table-driven, scoreboarded bench for mul_div_unit (honours MULDIV_DIV_EN)
module tb_mul_div_unit;
    import mul_div_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } sb_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    sb_t  sb[$];
    sb_t  mon_e;
    logic [31:0] m_hi, m_lo;
    vec_t tbl[12];

    mul_div_if md();

    mul_div_unit dut (
        .clock(clk),
        .reset(rst_n),
        .md   (md)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pops the oldest expected commit
    always @(posedge clk) begin
        if (rst_n && md.done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                mon_e = sb.pop_front();
                chk("hi", md.hi, mon_e.hi);
                chk("lo", md.lo, mon_e.lo);
                chk("divByZero", {31'b0, md.divByZero}, {31'b0, mon_e.dz});
            end
        end
    end

    task automatic push_exp(input logic [1:0] op, input logic [31:0] hi, input logic [31:0] lo, input logic dz);
        sb_t e;
`ifdef MULDIV_DIV_EN
        e = '{hi, lo, dz};
`else
        e = op[1] ? '{m_hi, m_lo, 1'b0} : '{hi, lo, 1'b0};
`endif
        m_hi = e.hi;
        m_lo = e.lo;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name, input int exp_busy);
        int nb;
        bit seen;
        nb = 0;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (md.busy) nb++;
            if (md.done) seen = 1;
            else @(posedge clk);
        end
        chk({name, "_done_seen"}, {31'b0, seen}, 32'd1);
        chk({name, "_busy_cycles"}, nb, exp_busy);
        @(posedge clk);
        chk({name, "_done_pulse"}, {31'b0, md.done}, 32'd0);
    endtask

    task automatic do_op(input vec_t v);
        int eb;
`ifdef MULDIV_DIV_EN
        eb = 33;
`else
        eb = v.op[1] ? 1 : 33;
`endif
        md.start = 1'b1;
        md.op    = v.op;
        md.opA   = v.a;
        md.opB   = v.b;
        push_exp(v.op, v.hi, v.lo, v.dz);
        @(posedge clk);
        md.start = 1'b0;
        wait_done("op", eb);
    endtask

    initial begin
        tbl[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        tbl[4]  = '{MD_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        tbl[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        tbl[6]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[7]  = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0};
        tbl[8]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        tbl[9]  = '{MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'h00000001, 1'b1};
        tbl[10] = '{MD_MULTU, 32'h12345678, 32'h10,       32'd1,        32'h23456780, 1'b0};
        tbl[11] = '{MD_DIVU,  32'd9,        32'd3,        32'd0,        32'd3,        1'b0};

        m_hi = '0;
        m_lo = '0;
        rst_n = 1'b0;
        md.start = 1'b0;
        md.op = '0;
        md.opA = '0;
        md.opB = '0;
        md.hiLoWrite = 1'b0;
        md.hiLoSel = 1'b0;
        md.hiLoData = '0;
        md.flush = 1'b0;

        // Reset state
        #12;
        chk("rst_hi", md.hi, 32'd0);
        chk("rst_lo", md.lo, 32'd0);
        chk("rst_busy", {31'b0, md.busy}, 32'd0);
        chk("rst_done", {31'b0, md.done}, 32'd0);
        chk("rst_dz", {31'b0, md.divByZero}, 32'd0);
        @(posedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        // Table of operations
        for (int i = 0; i < 12; i++) do_op(tbl[i]);

        // MTLO, then an operation that is flushed mid-CALC with a stray start in between
        md.hiLoWrite = 1'b1;
        md.hiLoSel = 1'b0;
        md.hiLoData = 32'h1234;
        @(posedge clk);
        md.hiLoWrite = 1'b0;
        m_lo = 32'h1234;
        chk("mtlo", md.lo, 32'h1234);
        md.start = 1'b1;
        md.op = MD_MULTU;
        md.opA = 32'd2;
        md.opB = 32'd3;
        @(posedge clk);
        md.start = 1'b0;
        chk("flush_busy_start", {31'b0, md.busy}, 32'd1);
        repeat (4) @(posedge clk);
        md.start = 1'b1;
        md.op = MD_DIVU;
        md.opA = 32'd50;
        md.opB = 32'd5;
        @(posedge clk);
        md.start = 1'b0;
        repeat (4) @(posedge clk);
        md.flush = 1'b1;
        @(posedge clk);
        md.flush = 1'b0;
        chk("flush_busy", {31'b0, md.busy}, 32'd0);
        chk("flush_lo", md.lo, 32'h1234);
        begin
            int nd;
            nd = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                if (md.done) nd++;
            end
            chk("flush_no_done", nd, 0);
        end
        chk("flush_lo_after", md.lo, 32'h1234);

        // MTHI in the same cycle as start: write lands now, the product overwrites later
        md.hiLoWrite = 1'b1;
        md.hiLoSel = 1'b1;
        md.hiLoData = 32'hABCD;
        md.start = 1'b1;
        md.op = MD_MULTU;
        md.opA = 32'd2;
        md.opB = 32'd3;
        push_exp(MD_MULTU, 32'd0, 32'd6, 1'b0);
        @(posedge clk);
        md.hiLoWrite = 1'b0;
        md.start = 1'b0;
        chk("mthi_with_start", md.hi, 32'hABCD);
        wait_done("wr_start", 33);

        // Reset asserted during CALC clears everything immediately
        md.hiLoWrite = 1'b1;
        md.hiLoSel = 1'b1;
        md.hiLoData = 32'h55;
        md.start = 1'b1;
        md.op = MD_MULT;
        md.opA = 32'd9;
        md.opB = 32'd9;
        @(posedge clk);
        md.hiLoWrite = 1'b0;
        md.start = 1'b0;
        repeat (5) @(posedge clk);
        chk("pre_rst_busy", {31'b0, md.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", md.hi, 32'd0);
        chk("midrst_lo", md.lo, 32'd0);
        chk("midrst_busy", {31'b0, md.busy}, 32'd0);
        chk("midrst_done", {31'b0, md.done}, 32'd0);
        @(posedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        chk("post_rst_busy", {31'b0, md.busy}, 32'd0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
